fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 153 +++++++++++++++
 tb/tb_fetch_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage feeding decode.
//
// Keeps the fetch PC and issues one sequential read per cycle to a synchronous
// program memory with 1-cycle read latency. Returned words are queued in a
// DEPTH-entry prefetch FIFO and offered to decode over a valid/ready handshake.
// A redirect flushes every buffered and in-flight instruction and restarts
// fetch at the (word-aligned) target.
//
// Optional feature macro: FETCH_BYPASS_EN
//   When defined, a response arriving while the FIFO is empty is presented to
//   decode in the same cycle; it is only written into the FIFO if decode does
//   not take it. Redirect-to-valid latency drops from 3 to 2 cycles.
//
// Parameters:
//   DEPTH    - prefetch FIFO entries (power of two, >= 2)
//   RESET_PC - fetch address after reset (word aligned)
//
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   imem_req         - read strobe to program memory
//   imem_addr        - read address (meaningful when imem_req=1)
//   imem_rdata       - read data, valid the cycle after a request
//   redirect_valid   - taken branch/jump: flush and refetch
//   redirect_pc      - new fetch address (low 2 bits ignored)
//   out_valid        - instruction/pc valid to decode
//   out_ready        - decode accepts this cycle
//   out_instruction  - instruction word (NOP when nothing buffered)
//   out_pc           - address of out_instruction (0 when nothing buffered)
module fetch_stage #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc
);

    localparam int unsigned PW      = $clog2(DEPTH);
    localparam int unsigned CW      = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]   fifo_instr_q [DEPTH];
    logic [31:0]   fifo_pc_q    [DEPTH];

    logic          head_valid;
    logic          bypass_valid;
    logic [CW:0]   occupancy;
    logic          push;
    logic          pop;

    always_comb begin
        head_valid = (count_q != '0);

        bypass_valid = 1'b0;
`ifdef FETCH_BYPASS_EN
        // Response cycle with nothing queued ahead of it: hand it straight on.
        bypass_valid = !rst && !redirect_valid && !head_valid && inflight_q;
`endif

        // Credit: buffered entries plus the one in flight never exceed DEPTH,
        // so a response always has a free slot to land in.
        occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        imem_req  = !rst && !redirect_valid && (occupancy < DEPTH_W);
        imem_addr = rst ? RESET_PC : fetch_pc_q;

        out_valid       = (!rst && !redirect_valid && head_valid) || bypass_valid;
        out_instruction = NOP;
        out_pc          = '0;
        if (!rst) begin
            if (head_valid) begin
                out_instruction = fifo_instr_q[rd_ptr_q];
                out_pc          = fifo_pc_q[rd_ptr_q];
            end else if (bypass_valid) begin
                out_instruction = imem_rdata;
                out_pc          = inflight_pc_q;
            end
        end

        pop  = out_valid && out_ready && head_valid;
        // A bypassed response that decode took is consumed, not stored.
        push = !rst && !redirect_valid && inflight_q && !(bypass_valid && out_ready);

        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~32'h0000_0003;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (imem_req) begin
                fetch_pc_d    = fetch_pc_q + 32'd4;
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // FIFO payload needs no reset: entries are only read while count_q covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr_q[wr_ptr_q] <= imem_rdata;
            fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam int unsigned DEPTH = 4;
`ifdef FETCH_BYPASS_EN
    localparam int unsigned LAT = 2;
    localparam bit          BYP = 1'b1;
`else
    localparam int unsigned LAT = 3;
    localparam bit          BYP = 1'b0;
`endif
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main DUT (RESET_PC = 0)
    logic        rst, redirect_valid, out_ready;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, out_valid;
    logic [31:0] imem_addr, out_instruction, out_pc;

    // second DUT starting near the top of the address space
    logic        redirect_valid_w, out_ready_w;
    logic [31:0] redirect_pc_w, imem_rdata_w;
    logic        imem_req_w, out_valid_w;
    logic [31:0] imem_addr_w, out_instruction_w, out_pc_w;

    fetch_stage #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_pc(out_pc)
    );

    fetch_stage #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
        .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w),
        .out_instruction(out_instruction_w), .out_pc(out_pc_w)
    );

    // program memory contents: a fixed scramble of the address
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    int unsigned total  = 0;
    int unsigned passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    endtask

    // reference model: fetch address, the one outstanding read, and the
    // ordered list of pcs buffered for decode
    logic [31:0] m_fpc  = 32'h0;
    bit          m_pend = 1'b0;
    logic [31:0] m_ppc  = 32'h0;
    logic [31:0] m_q[$];

    // stream property: the next accepted pc is last+4, or the latest restart target
    logic [31:0] seq_next = 32'h0;

    // sampled DUT outputs of the last cycle
    logic        s_req, s_ov;
    logic [31:0] s_addr, s_pc, s_ins;
    logic        cap_req, cap_req_w;
    logic [31:0] cap_addr, cap_addr_w;

    logic [31:0] wpc[3];
    int unsigned wn = 0;

    task automatic tick();
        int          qn;
        bit          e_req, e_byp, e_ov;
        logic [31:0] e_pc, e_ins;
        @(negedge clk);
        s_req = imem_req; s_addr = imem_addr; s_ov = out_valid;
        s_pc = out_pc; s_ins = out_instruction;

        qn    = m_q.size();
        e_req = !rst && !redirect_valid && (qn + int'(m_pend) < int'(DEPTH));
        e_byp = BYP && !rst && !redirect_valid && qn == 0 && m_pend;
        e_ov  = !rst && !redirect_valid && (qn > 0 || e_byp);
        e_pc  = 32'h0;
        e_ins = NOP;
        if (!rst) begin
            if (qn > 0) begin
                e_pc = m_q[0]; e_ins = memf(m_q[0]);
            end else if (e_byp) begin
                e_pc = m_ppc; e_ins = memf(m_ppc);
            end
        end

        chk("req", 32'(s_req), 32'(e_req));
        if (e_req || rst) chk("addr", s_addr, rst ? 32'h0 : m_fpc);
        chk("valid", 32'(s_ov), 32'(e_ov));
        if (e_ov || rst || qn == 0) begin
            chk("pc", s_pc, e_pc);
            chk("instr", s_ins, e_ins);
        end
        if (e_ov && out_ready) begin
            chk("seq", s_pc, seq_next);
            seq_next = s_pc + 32'd4;
        end

        if (out_valid_w) begin
            chk("wrap_instr", out_instruction_w, memf(out_pc_w));
            if (wn < 3) begin
                wpc[wn] = out_pc_w;
                wn++;
            end
        end

        if (rst) begin
            m_fpc = 32'h0; m_pend = 1'b0; m_q.delete();
            seq_next = 32'h0;
        end else if (redirect_valid) begin
            m_q.delete(); m_pend = 1'b0;
            m_fpc = {redirect_pc[31:2], 2'b00};
            seq_next = m_fpc;
        end else begin
            if (e_ov && out_ready && qn > 0) void'(m_q.pop_front());
            if (m_pend && !(e_byp && out_ready)) m_q.push_back(m_ppc);
            m_pend = e_req;
            if (e_req) begin
                m_ppc = m_fpc;
                m_fpc = m_fpc + 32'd4;
            end
        end

        cap_req = imem_req; cap_addr = imem_addr;
        cap_req_w = imem_req_w; cap_addr_w = imem_addr_w;
        @(posedge clk);
        #1;
        imem_rdata   = cap_req   ? memf(cap_addr)   : $urandom();
        imem_rdata_w = cap_req_w ? memf(cap_addr_w) : $urandom();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req", 32'(s_req), 32'h0);
        chk("rst_addr", s_addr, 32'h0);
        chk("rst_valid", 32'(s_ov), 32'h0);
        chk("rst_instr", s_ins, NOP);
        chk("rst_pc", s_pc, 32'h0);
    endtask

    // after a reset or redirect: request for the target next cycle, valid after LAT
    task automatic expect_restart(input logic [31:0] exp_pc);
        for (int k = 1; k <= int'(LAT); k++) begin
            tick();
            if (k == 1) begin
                chk("restart_req", 32'(s_req), 32'h1);
                chk("restart_addr", s_addr, exp_pc);
            end
            if (k < int'(LAT)) chk("restart_gap", 32'(s_ov), 32'h0);
            else begin
                chk("restart_valid", 32'(s_ov), 32'h1);
                chk("restart_pc", s_pc, exp_pc);
            end
        end
    endtask

    task automatic redirect_to(input logic [31:0] tgt, input logic [31:0] exp_pc);
        redirect_valid = 1'b1; redirect_pc = tgt; out_ready = 1'b1;
        tick();
        chk("redir_valid_R", 32'(s_ov), 32'h0);
        chk("redir_req_R", 32'(s_req), 32'h0);
        redirect_valid = 1'b0;
        expect_restart(exp_pc);
    endtask

    logic [31:0] pa[8];
    logic        va[8];
    logic        ra[8];
    logic [31:0] aa[8];
    int unsigned nreq;
    logic [31:0] last_addr;

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
        redirect_valid_w = 1'b0; redirect_pc_w = 32'h0; out_ready_w = 1'b1;
        imem_rdata = 32'h0; imem_rdata_w = 32'h0;

        // streaming from reset
        tick(); tick();
        chk_reset_outputs();
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            va[k] = s_ov; pa[k] = s_pc; ra[k] = s_req; aa[k] = s_addr;
        end
        chk("first_req", 32'(ra[1]), 32'h1);
        chk("first_addr", aa[1], 32'h0);
        chk("first_gap", 32'(va[LAT-1]), 32'h0);
        for (int j = 0; j < 3; j++) begin
            chk("stream_valid", 32'(va[int'(LAT)+j]), 32'h1);
            chk("stream_pc", pa[int'(LAT)+j], 32'(4*j));
        end

        // decode stalled: credit limit and stable head
        rst = 1'b1; tick(); rst = 1'b0; out_ready = 1'b0;
        nreq = 0; last_addr = 32'h0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (s_req) begin nreq++; last_addr = s_addr; end
            if (s_ov) chk("hold_pc", s_pc, 32'h0);
        end
        chk("stall_nreq", 32'(nreq), 32'd4);
        chk("stall_last_addr", last_addr, 32'h0000_000C);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("drain_valid", 32'(s_ov), 32'h1);
            chk("drain_pc", s_pc, 32'(4*k));
        end

        // redirect with three buffered entries and one read outstanding
        rst = 1'b1; tick(); rst = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        redirect_to(32'h0000_0100, 32'h0000_0100);
        for (int k = 0; k < 8; k++) tick();

        // unaligned target
        redirect_to(32'h0000_0203, 32'h0000_0200);
        for (int k = 0; k < 4; k++) tick();

        // reset in mid-stream with a read outstanding
        for (int k = 0; k < 5; k++) tick();
        rst = 1'b1;
        tick();
        chk_reset_outputs();
        rst = 1'b0;
        expect_restart(32'h0000_0000);

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 299) == 0);
            redirect_valid = !rst && ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else redirect_pc = $urandom();
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 10; k++) tick();

        chk("wrap_count", 32'(wn), 32'd3);
        chk("wrap_pc0", wpc[0], 32'hFFFF_FFF8);
        chk("wrap_pc1", wpc[1], 32'hFFFF_FFFC);
        chk("wrap_pc2", wpc[2], 32'h0000_0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
